t_proc_sched: RTL
=================

Name: t_proc_sched

Overview:
- Tile scheduler that sequences the ternary select array over a convolution layer.
- Walks output-channel tiles (m) and input-channel tiles (n): requests the (m,n) weight tile, pulses kernel_valid to latch it, then streams feature windows into the array.
- Drives accumulator enables aligned to array latency. Signals per-m-tile completion and layer completion.
- Sits between the layer control registers, weight buffer, feature window generator and accumulator bank.

Parameters:
- Tm, `Tm, output-channel parallelism (documentation/consistency only)
- Tn, `Tn, input-channel parallelism (documentation/consistency only)
- CNT_W, 8, width of tile-count config/counters
- PIX_W, 12, width of pixel-count config/counter
- ADDR_W, 16, width of weight tile address
- PIPE_LAT, 1, cycles from feature handshake to select_out valid; legal 1..7

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle layer start; honoured only in IDLE
- num_m_tiles  in  CNT_W  m-tile count, sampled at start
- num_n_tiles  in  CNT_W  n-tile count, sampled at start
- num_pix  in  PIX_W  output pixels per tile, sampled at start
- weight_req  out  1  held high until weight_ready
- weight_addr  out  ADDR_W  tile index m*num_n_tiles+n, stable while weight_req high
- weight_ready  in  1  weight tile present on array weight bus
- kernel_valid  out  1  one-cycle pulse latching weights into array
- feat_valid  in  1  feature window valid
- feat_ready  out  1  scheduler accepting windows
- acc_en  out  1  accumulate select_out this cycle
- acc_first  out  1  with acc_en: overwrite instead of add (n==0)
- pix_idx  out  PIX_W  pixel index qualified by acc_en
- tile_done  out  1  one-cycle pulse: m-tile fully accumulated
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse: layer complete

Behaviour:
- Reset (rst low, async): state IDLE; all counters 0; every output 0.
- Zero-count config: if any of num_m_tiles/num_n_tiles/num_pix is 0 at start, done pulses the next cycle, busy stays 0, no weight_req.
- IDLE:
  - On start with nonzero config: latch config, clear m/n, go REQ_W.
  - start while busy is ignored.
- REQ_W:
  - weight_req=1, weight_addr valid.
  - On weight_ready=1 go LATCH (same cycle weight_req still high).
- LATCH:
  - kernel_valid=1 for exactly one cycle; pixel counter cleared; go STREAM.
- STREAM:
  - feat_ready=1. A handshake is feat_valid&feat_ready.
  - Each handshake increments the pixel counter.
  - The handshake pushes {1, n==0, pix} into a PIPE_LAT-deep shift pipeline; the pipeline output drives acc_en/acc_first/pix_idx.
  - Cycles without a handshake push a bubble (acc_en=0).
  - On the num_pix-th handshake, feat_ready drops the next cycle; go DRAIN.
- DRAIN:
  - Counts PIPE_LAT cycles with feat_ready=0, pipeline still shifting.
  - After PIPE_LAT cycles (last acc_en emitted), go NEXT.
- NEXT (1 cycle):
  - If n==num_n_tiles-1: pulse tile_done, set n=0.
    - If m==num_m_tiles-1: pulse done, go IDLE.
    - Else m++ and go REQ_W.
  - Else n++ and go REQ_W.
- Fixed ordering: n inner, m outer. weight_addr increments by 1 per tile from 0 to M*N-1.
- Latency: kernel_valid precedes first feat_ready by 1 cycle. acc_en trails its handshake by exactly PIPE_LAT cycles.
- Counter arithmetic:
  - weight_addr is a running counter, not a multiply, truncated to ADDR_W.
  - Config must satisfy M*N ≤ 2^ADDR_W; behaviour beyond that is undefined.
- Simultaneous tile_done and done pulse in the same cycle on the final tile.
- Reset mid-operation: immediate return to IDLE. The pipeline is flushed and no acc_en/tile_done/done is emitted afterwards. A new start is required.

Test Plan:
- M=1,N=1,P=4, weight_ready one cycle after req, feat_valid constant -> weight_addr 0, one kernel_valid, 4 acc_en all with acc_first=1, pix_idx 0..3, tile_done and done together, busy low after.
- M=2,N=2,P=3 -> weight_addr sequence 0,1,2,3, 4 kernel_valid pulses, acc_first=1 only for addr 0 and 2, tile_done twice, done once, 12 acc_en total.
- P=5 with feat_valid pattern 1,0,0,1,1,0,1,1 -> exactly 5 handshakes, acc_en mirrors handshakes delayed PIPE_LAT, feat_ready low after 5th.
- weight_ready withheld 10 cycles -> weight_req and weight_addr held stable 10 cycles, kernel_valid only after ready, no feat_ready meanwhile.
- start with num_n_tiles=0 -> done pulse next cycle, no weight_req; start asserted during STREAM -> ignored, counters unaffected.
- rst low mid-STREAM of M=2,N=2,P=8 at pixel 3 -> all outputs 0 asynchronously, no later acc_en; fresh start restarts at weight_addr 0.

Source files
------------

// File: rtl/t_proc_sched.sv
// t_proc_sched: tile scheduler sequencing the ternary select array over one
// convolution layer (n tiles inner, m tiles outer).
// Ports:
//   clk, rst (async, active-low)
//   start, num_m_tiles, num_n_tiles, num_pix       layer config, sampled at start
//   weight_req/weight_addr/weight_ready            weight tile fetch
//   kernel_valid                                   latches weights into array
//   feat_valid/feat_ready                          feature window handshake
//   acc_en/acc_first/pix_idx                       accumulator control
//   tile_done, busy, done                          status
module t_proc_sched #(
  parameter int Tm       = 8,
  parameter int Tn       = 8,
  parameter int CNT_W    = 8,
  parameter int PIX_W    = 12,
  parameter int ADDR_W   = 16,
  parameter int PIPE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_m_tiles,
  input  logic [CNT_W-1:0]  num_n_tiles,
  input  logic [PIX_W-1:0]  num_pix,
  output logic              weight_req,
  output logic [ADDR_W-1:0] weight_addr,
  input  logic              weight_ready,
  output logic              kernel_valid,
  input  logic              feat_valid,
  output logic              feat_ready,
  output logic              acc_en,
  output logic              acc_first,
  output logic [PIX_W-1:0]  pix_idx,
  output logic              tile_done,
  output logic              busy,
  output logic              done
);

  // An illegal build (latency out of range, empty array) degenerates every
  // layer to the empty case: done pulses, nothing is scheduled.
  localparam bit CFG_OK = (PIPE_LAT >= 1) && (PIPE_LAT <= 7) &&
                          (Tm > 0) && (Tn > 0);
  localparam logic [2:0] LAT_LAST = 3'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_W,
    S_LATCH,
    S_STREAM,
    S_DRAIN,
    S_NEXT
  } state_e;

  state_e state_q;

  logic [CNT_W-1:0]  m_q, n_q, m_tot_q, n_tot_q;
  logic [PIX_W-1:0]  p_tot_q, pix_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        drn_q;
  logic              req_q, kv_q, fr_q, td_q, busy_q, done_q;

  logic hs, last_n, last_m, last_pix, cfg_empty;

  assign hs        = fr_q & feat_valid;
  assign last_n    = (n_q == n_tot_q - CNT_W'(1));
  assign last_m    = (m_q == m_tot_q - CNT_W'(1));
  assign last_pix  = (pix_q == p_tot_q - PIX_W'(1));
  assign cfg_empty = !CFG_OK || (num_m_tiles == '0) ||
                     (num_n_tiles == '0) || (num_pix == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      m_tot_q <= '0;
      n_tot_q <= '0;
      p_tot_q <= '0;
      pix_q   <= '0;
      addr_q  <= '0;
      drn_q   <= '0;
      req_q   <= 1'b0;
      kv_q    <= 1'b0;
      fr_q    <= 1'b0;
      td_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      kv_q   <= 1'b0;
      td_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_empty) begin
              done_q <= 1'b1;
            end else begin
              m_tot_q <= num_m_tiles;
              n_tot_q <= num_n_tiles;
              p_tot_q <= num_pix;
              m_q     <= '0;
              n_q     <= '0;
              addr_q  <= '0;
              req_q   <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= S_REQ_W;
            end
          end
        end
        S_REQ_W: begin
          if (weight_ready) begin
            req_q   <= 1'b0;
            kv_q    <= 1'b1;
            pix_q   <= '0;
            state_q <= S_LATCH;
          end
        end
        S_LATCH: begin
          fr_q    <= 1'b1;
          state_q <= S_STREAM;
        end
        S_STREAM: begin
          if (hs) begin
            pix_q <= pix_q + PIX_W'(1);
            if (last_pix) begin
              fr_q    <= 1'b0;
              drn_q   <= '0;
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Leaves on the cycle the final acc_en leaves the pipeline.
          if (drn_q == LAT_LAST) begin
            td_q    <= last_n;
            done_q  <= last_n & last_m;
            state_q <= S_NEXT;
          end else begin
            drn_q <= drn_q + 3'd1;
          end
        end
        S_NEXT: begin
          if (last_n && last_m) begin
            n_q     <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            if (last_n) begin
              n_q <= '0;
              m_q <= m_q + CNT_W'(1);
            end else begin
              n_q <= n_q + CNT_W'(1);
            end
            addr_q  <= addr_q + ADDR_W'(1);
            req_q   <= 1'b1;
            state_q <= S_REQ_W;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake pipeline: shifts every cycle, bubbles carry valid=0.
  logic [PIPE_LAT-1:0] pv_q, pf_q;
  logic [PIX_W-1:0]    pp_q [PIPE_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv_q <= '0;
      pf_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) pp_q[i] <= '0;
    end else begin
      pv_q[0] <= hs;
      pf_q[0] <= hs & (n_q == '0);
      pp_q[0] <= hs ? pix_q : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pf_q[i] <= pf_q[i-1];
        pp_q[i] <= pp_q[i-1];
      end
    end
  end

  assign weight_req   = req_q;
  assign weight_addr  = addr_q;
  assign kernel_valid = kv_q;
  assign feat_ready   = fr_q;
  assign acc_en       = pv_q[PIPE_LAT-1];
  assign acc_first    = pf_q[PIPE_LAT-1];
  assign pix_idx      = pp_q[PIPE_LAT-1];
  assign tile_done    = td_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
